// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared constants and buffer-state encoding for the FIFO read controller.
package fifo_rd_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int BUF_DEPTH  = 2;
    localparam int STAT_W     = 16;

    // Encoding doubles as the buffer occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/fifo_rd_ctrl_skid.sv
// rd_skid_buf: two-entry output buffer with a registered head word.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output buf_state_e        state,
    output logic [DATA_W-1:0] head
);

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = push ? ONE : EMPTY;
            ONE:     state_d = (push && !pop) ? TWO : (pop && !push) ? EMPTY : ONE;
            TWO:     state_d = (pop && !push) ? ONE : TWO;
            default: state_d = EMPTY;
        endcase
    end

    // A word arriving while the head leaves goes straight to the head.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if ((state_q == EMPTY && push) || (state_q == ONE && push && pop))
            head_d = din;
        if (state_q == TWO && pop)
            head_d = tail_q;
        if ((state_q == ONE && push && !pop) || (state_q == TWO && push && pop))
            tail_d = din;
        state = state_q;
        head  = head_q;
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: drives fifo_mem reads, hides its 1-cycle latency, outputs a valid/ready stream.
// Define FIFO_RD_STATS_EN to add the words_out and stall_cycles counters.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [STAT_W-1:0] words_out,
    output logic [STAT_W-1:0] stall_cycles
`endif
);

    logic       inflight_q, inflight_d, pop;
    logic [2:0] level;
    buf_state_e state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_q <= 1'b0;
        else     inflight_q <= inflight_d;
    end

    // Occupancy after this edge counts the word already in flight.
    always_comb begin
        m_valid    = state != EMPTY;
        pop        = m_valid & m_ready;
        level      = {1'b0, state} + {2'b0, inflight_q} - {2'b0, pop};
        fifo_rd    = ~rst & en & ~fifo_empty & (level < 3'(BUF_DEPTH));
        inflight_d = fifo_rd;
        busy       = inflight_q | m_valid;
    end

    rd_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop),
        .din   (fifo_data),
        .state (state),
        .head  (m_data)
    );

`ifdef FIFO_RD_STATS_EN
    logic [STAT_W-1:0] words_q, words_d, stall_q, stall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        words_d      = pop ? words_q + 1'b1 : words_q;
        stall_d      = (m_valid && !m_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        words_out    = words_q;
        stall_cycles = stall_q;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and table-driven checks of fifo_rd_ctrl against a fifo_mem model.
module tb_fifo_rd_ctrl;
    import fifo_rd_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en, fifo_empty, fifo_rd, m_valid, m_ready, busy;
    logic [W-1:0] fifo_data = '0;
    logic [W-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]  words_out, stall_cycles;
`endif

    logic [W-1:0] mem [512];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    int           sb_ptr = 0;
    int           pop_cnt = 0;
    int           total = 0;
    int           bad = 0;
    logic         flush = 1'b0, inf = 1'b0, sb_on = 1'b0;
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_data = '0;

    typedef struct {
        logic       en, rdy, rd, vld, bsy;
        logic [7:0] data;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.DATA_W(W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd      (fifo_rd),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy)
`ifdef FIFO_RD_STATS_EN
        ,
        .words_out    (words_out),
        .stall_cycles (stall_cycles)
`endif
    );

    // fifo_mem model: data appears the cycle after a read strobe.
    assign fifo_empty = (rd_ptr == wr_ptr) && !inf;
    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd) begin
            fifo_data <= mem[rd_ptr % 512];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    function automatic vec_t mk(logic e, logic r, logic rd, logic v, logic [7:0] d, logic b);
        vec_t x;
        x.en = e; x.rdy = r; x.rd = rd; x.vld = v; x.data = d; x.bsy = b;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic mon();
        chk("rd_when_empty", {31'b0, fifo_rd & fifo_empty}, 32'd0);
        chk("cap_in_two", {31'b0, (u_dut.u_buf.state_q == TWO) & u_dut.inflight_q}, 32'd0);
        if (hold_prev) chk("hold_stable", {m_valid, m_data}, {1'b1, hold_data});
        hold_prev = m_valid & ~m_ready;
        hold_data = m_data;
        if (m_valid && m_ready) begin
            pop_cnt++;
            if (sb_on) begin
                chk("order", {24'b0, m_data}, {24'b0, mem[sb_ptr % 512]});
                sb_ptr++;
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        to_neg();
        to_pos();
    endtask

    task automatic load(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 512] = rnd ? 8'($urandom) : 8'(i + 1);
            wr_ptr++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; m_ready = 1'b0; flush = 1'b1; hold_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        int n, start, rd_cnt;
        tbl[0] = mk(1, 0, 1, 0, 8'h00, 0);
        tbl[1] = mk(1, 0, 1, 0, 8'h00, 1);
        for (int i = 2; i < 10; i++) tbl[i] = mk(1, 0, 0, 1, 8'h01, 1);
        for (int i = 10; i < 14; i++) tbl[i] = mk(1, 1, 1, 1, 8'(i - 9), 1);

        rst = 1'b1; en = 1'b0; m_ready = 1'b0; flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;

        // reset state, then idle with an empty FIFO
        to_neg();
        chk("reset_out", {21'b0, fifo_rd, m_valid, busy, m_data}, 32'd0);
        to_pos();
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            to_neg();
            chk("idle", {29'b0, fifo_rd, m_valid, busy}, 32'd0);
            to_pos();
        end

        // latency and sustained throughput
        sb_on = 1'b1; sb_ptr = wr_ptr; m_ready = 1'b1;
        load(16, 0);
        to_neg();
        chk("lat_rd", {31'b0, fifo_rd}, 32'd1);
        chk("lat_v_n", {31'b0, m_valid}, 32'd0);
        to_pos(); to_neg();
        chk("lat_v_n1", {31'b0, m_valid}, 32'd0);
        to_pos(); to_neg();
        chk("lat_v_n2", {m_valid, m_data}, {1'b1, 8'h01});
        n = 0;
        while (sb_ptr != wr_ptr && n < 40) begin
            to_pos(); to_neg();
            n++;
        end
        chk("thru_cycles", n, 32'd15);
        to_pos(); to_neg();
        chk("drain_idle", {30'b0, m_valid, busy}, 32'd0);
        to_pos();

        // backpressure then release, table-driven
        sb_ptr = wr_ptr;
        load(16, 0);
        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en; m_ready = tbl[i].rdy;
            to_neg();
            chk($sformatf("vec%0d", i), {fifo_rd, m_valid, busy, m_valid ? m_data : 8'h00},
                {tbl[i].rd, tbl[i].vld, tbl[i].bsy, tbl[i].data});
            if (i == 9) chk("state_two", {30'b0, u_dut.u_buf.state_q}, {30'b0, TWO});
            to_pos();
        end
        for (int k = 5; k <= 16; k++) begin
            to_neg();
            chk("bp_drain", {m_valid, m_data}, {1'b1, 8'(k)});
            to_pos();
        end
        to_neg();
        chk("bp_idle", {30'b0, m_valid, busy}, 32'd0);
        to_pos();

        // random backpressure over random words
        void'($urandom(5));
        sb_ptr = wr_ptr;
        load(64, 1);
        n = 0;
        while (sb_ptr != wr_ptr && n < 1000) begin
            m_ready = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        chk("rand_all_out", sb_ptr, wr_ptr);
        m_ready = 1'b0;
        cyc(); cyc();
        to_neg();
        chk("rand_idle", {30'b0, m_valid, busy}, 32'd0);
        to_pos();

        // en dropped with one word in flight and one buffered
        m_ready = 1'b1;
        start = wr_ptr; sb_ptr = wr_ptr;
        load(4, 0);
        cyc(); cyc();
        en = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            to_neg();
            rd_cnt += int'(fifo_rd);
            if (i == 1) chk("en_drop_busy1", {31'b0, busy}, 32'd1);
            if (i == 2) chk("en_drop_busy0", {31'b0, busy}, 32'd0);
            to_pos();
        end
        chk("en_drop_rd", rd_cnt, 32'd0);
        chk("en_drop_words", sb_ptr - start, 32'd2);
        flush = 1'b1;
        to_pos();
        flush = 1'b0;

        // asynchronous reset mid-operation
        sb_on = 1'b0; en = 1'b1; m_ready = 1'b0;
        load(4, 0);
        cyc(); cyc(); cyc();
        chk("pre_rst_valid", {30'b0, m_valid, busy}, 32'd3);
        #2;
        rst = 1'b1; flush = 1'b1; hold_prev = 1'b0;
        #1;
        chk("async_rst", {21'b0, fifo_rd, m_valid, busy, m_data}, 32'd0);
        to_pos();
        rst = 1'b0; flush = 1'b0; en = 1'b0;
        sb_on = 1'b1;
        cyc();

`ifdef FIFO_RD_STATS_EN
        do_reset();
        en = 1'b1; sb_ptr = wr_ptr;
        load(3, 0);
        repeat (6) cyc();
        m_ready = 1'b1;
        repeat (6) cyc();
        chk("words_out", {16'b0, words_out}, 32'd3);
        chk("stall_cycles", {16'b0, stall_cycles}, 32'd4);

        do_reset();
        sb_on = 1'b0; inf = 1'b1; en = 1'b1; m_ready = 1'b1; pop_cnt = 0;
        n = 0;
        while (n < 70000) begin
            to_neg();
            n++;
            if (pop_cnt == 65536) break;
            to_pos();
        end
        chk("wrap_pops", pop_cnt, 32'd65536);
        chk("words_ffff", {16'b0, words_out}, 32'h0000_FFFF);
        to_pos(); to_neg();
        chk("words_wrap", {16'b0, words_out}, 32'd0);
        to_pos();
        en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
